// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with a valid/ready handshake, a one-deep output register,
// an accumulator that can stand in for operand B, and a saturating accepted-transaction count.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_parity,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] y_reg;
    logic             y_zero_reg;
    logic             y_parity_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH-1:0] bq;
    logic [WIDTH-1:0] result_next;
    logic             accept;

    // The output slot is free when empty or when it is being drained this cycle.
    assign in_ready = ~out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;
    assign bq       = acc ? acc_reg : b;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic bit_next;
            always_comb begin
                bit_next = 1'b0;
                unique case (op)
                    3'b000: bit_next =   a[gi] & bq[gi];
                    3'b001: bit_next = ~(a[gi] & bq[gi]);
                    3'b010: bit_next = ~(a[gi] ^ bq[gi]);
                    3'b011: bit_next =   a[gi] | bq[gi];
                    3'b100: bit_next = ~(a[gi] | bq[gi]);
                    3'b101: bit_next =   a[gi] ^ bq[gi];
                    3'b110: bit_next =   a[gi];
                    3'b111: bit_next =  ~a[gi];
                    default: bit_next = 1'b0;
                endcase
            end
            assign result_next[gi] = bit_next;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= '0;
            y_zero_reg    <= 1'b1;
            y_parity_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            if (accept) begin
                y_reg        <= result_next;
                y_zero_reg   <= ~|result_next;
                y_parity_reg <= ^result_next;
            end

            if (accept)
                out_valid_reg <= 1'b1;
            else if (out_ready)
                out_valid_reg <= 1'b0;

            // Clear beats the update so a colliding transaction still sees the old value as Bq.
            if (acc_clr)
                acc_reg <= '0;
            else if (accept)
                acc_reg <= result_next;

            if (accept && !(&cnt_reg))
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign y         = y_reg;
    assign y_zero    = y_zero_reg;
    assign y_parity  = y_parity_reg;
    assign out_valid = out_valid_reg;
    assign cnt       = cnt_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: reset, all eight ops, backpressure, accumulator use,
// clear collision, and counter saturation on a narrow-counter second instance.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        acc;
    logic        acc_clr;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  y;
    logic        y_zero;
    logic        y_parity;
    logic [15:0] cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  y2;
    logic        y_zero2;
    logic        y_parity2;
    logic [1:0]  cnt2;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .acc(acc), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .y_zero(y_zero), .y_parity(y_parity), .cnt(cnt)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .op(op), .acc(acc), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .y(y2),
        .y_zero(y_zero2), .y_parity(y_parity2), .cnt(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Leave a stalled result in the output register, then reset mid-cycle.
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b011; acc = 1'b0; a = 8'h12; b = 8'h34;
        step();
        in_valid = 1'b0;
        assertions++;
        if (out_valid !== 1'b1 || y !== 8'h36) begin
            failures++;
            $display("FAIL reset_pre: out_valid=%b y=%h required out_valid=1 y=36", out_valid, y);
        end
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if (out_valid !== 1'b0 || y !== 8'h00 || y_zero !== 1'b1 || y_parity !== 1'b0 ||
            cnt !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_async: ov=%b y=%h z=%b p=%b cnt=%0d ir=%b required 0 00 1 0 0 1",
                     out_valid, y, y_zero, y_parity, cnt, in_ready);
        end
        $display("reset: ov=%b y=%h z=%b p=%b cnt=%0d ir=%b", out_valid, y, y_zero, y_parity, cnt, in_ready);
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_ops();
        logic [7:0] exp_y [8] = '{8'hC0, 8'h3F, 8'hC3, 8'hFC, 8'h03, 8'h3C, 8'hF0, 8'h0F};
        out_ready = 1'b1; acc = 1'b0; acc_clr = 1'b0; a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            step();
            assertions++;
            if (y !== exp_y[i] || out_valid !== 1'b1 || y_zero !== (exp_y[i] == 8'h00) ||
                y_parity !== ^exp_y[i]) begin
                failures++;
                $display("FAIL basic_op%0d: y=%h ov=%b z=%b p=%b required y=%h ov=1 z=%b p=%b",
                         i, y, out_valid, y_zero, y_parity, exp_y[i], exp_y[i] == 8'h00, ^exp_y[i]);
            end
            $display("op=%0d a=F0 b=CC -> y=%h", i, y);
        end
        in_valid = 1'b0;
        step();
        assertions++;
        if (cnt !== 16'd8 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_cnt: cnt=%0d ov=%b required cnt=8 ov=0", cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h0F;
        step();
        op = 3'b011;
        #1;
        assertions++;
        if (y !== 8'h0F || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_first: y=%h ov=%b ir=%b required y=0F ov=1 ir=0", y, out_valid, in_ready);
        end
        step();
        assertions++;
        if (y !== 8'h0F || cnt !== 16'd9 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: y=%h cnt=%0d ir=%b required y=0F cnt=9 ir=0", y, cnt, in_ready);
        end
        $display("backpressure hold: y=%h cnt=%0d", y, cnt);
        out_ready = 1'b1;
        #1;
        assertions++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready: ir=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        assertions++;
        if (y !== 8'hFF || cnt !== 16'd10 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: y=%h cnt=%0d ov=%b required y=FF cnt=10 ov=1", y, cnt, out_valid);
        end
        $display("backpressure release: y=%h cnt=%0d", y, cnt);
        step();
        assertions++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] a_seq [3] = '{8'h0F, 8'hFF, 8'hF0};
        logic [7:0] y_seq [3] = '{8'h0F, 8'hF0, 8'h00};
        out_ready = 1'b1; in_valid = 1'b0; acc_clr = 1'b1;
        step();
        acc_clr = 1'b0; acc = 1'b1; op = 3'b101; b = 8'hAA; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = a_seq[i];
            step();
            assertions++;
            if (y !== y_seq[i] || y_zero !== (y_seq[i] == 8'h00) || y_parity !== ^y_seq[i]) begin
                failures++;
                $display("FAIL acc_step%0d: y=%h z=%b p=%b required y=%h z=%b p=%b",
                         i, y, y_zero, y_parity, y_seq[i], y_seq[i] == 8'h00, ^y_seq[i]);
            end
            $display("acc xor a=%h -> y=%h z=%b p=%b", a, y, y_zero, y_parity);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_clear_collision();
        out_ready = 1'b1; in_valid = 1'b1; acc = 1'b0; op = 3'b110; a = 8'h55; b = 8'h00;
        step();
        assertions++;
        if (y !== 8'h55) begin
            failures++;
            $display("FAIL clr_load: y=%h required 55", y);
        end
        acc = 1'b1; op = 3'b011; a = 8'hAA; acc_clr = 1'b1;
        step();
        assertions++;
        if (y !== 8'hFF) begin
            failures++;
            $display("FAIL clr_collide: y=%h required FF", y);
        end
        $display("clear collision: y=%h", y);
        acc_clr = 1'b0; a = 8'h00;
        step();
        in_valid = 1'b0;
        assertions++;
        if (y !== 8'h00 || y_zero !== 1'b1) begin
            failures++;
            $display("FAIL clr_after: y=%h z=%b required y=00 z=1", y, y_zero);
        end
        $display("after clear: y=%h z=%b", y, y_zero);
        step();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        #2 rst_n = 1'b0;
        #3;
        assertions++;
        if (cnt2 !== 2'd0) begin
            failures++;
            $display("FAIL sat_reset: cnt=%0d required 0", cnt2);
        end
        step();
        #2 rst_n = 1'b1;
        out_ready = 1'b1; acc = 1'b0; acc_clr = 1'b0; op = 3'b000; a = 8'h01; b = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            assertions++;
            if (cnt2 !== exp_cnt[i]) begin
                failures++;
                $display("FAIL sat_cnt%0d: cnt=%0d required %0d", i, cnt2, exp_cnt[i]);
            end
            $display("saturation accept %0d: cnt=%0d", i + 1, cnt2);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; acc = 1'b0; acc_clr = 1'b0;
        a = 8'h00; b = 8'h00; out_ready = 1'b1;
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        test_reset();
        test_basic_ops();
        test_backpressure();
        test_accumulate();
        test_clear_collision();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
